// File: rtl/pcie_tx_arb_pkg.sv
// pcie_tx_arb_pkg: shared types and constants for the PCIe TX round-robin arbiter.
package pcie_tx_arb_pkg;
    typedef enum logic {IDLE, XFER} state_t;
    localparam int TUSER_WIDTH = 4;
    localparam int MAX_REQ = 4;
endpackage

// File: rtl/pcie_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin choice of the first requester after the pointer.
module rr_pick
    import pcie_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic               valid_o,
    output logic [1:0]         idx_o
);
    logic [MAX_REQ-1:0] req_x;
    logic [1:0]         cand;
    assign req_x   = MAX_REQ'(req_i);
    assign valid_o = |req_i;
    // Scan from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        idx_o = '0;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = 2'((int'(ptr_i) + k) % NUM_REQ);
            if (req_x[cand]) idx_o = cand;
        end
    end
endmodule

// File: rtl/pcie_tx_arbiter.sv
// pcie_tx_arbiter: packet-granular round-robin sharing of the PCIe TX AXI-Stream port.
// Define PCIE_TX_ARB_WDT_EN to revoke grants that never start a packet.
module pcie_tx_arbiter
    import pcie_tx_arb_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int NUM_REQ      = 2,
    parameter int WDT_CYCLES   = 256
) (
    input  logic                            pcie_clk,
    input  logic                            pcie_rst_n,
    input  logic [NUM_REQ-1:0]              pcie_in_req,
    output logic [NUM_REQ-1:0]              pcie_in_ack,
    input  logic [NUM_REQ-1:0]              pcie_in_tvalid,
    input  logic [NUM_REQ-1:0]              pcie_in_tlast,
    input  logic [NUM_REQ*C_DATA_WIDTH-1:0] pcie_in_tdata,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0]   pcie_in_tkeep,
    input  logic [NUM_REQ*TUSER_WIDTH-1:0]  pcie_in_tuser,
    output logic [NUM_REQ-1:0]              pcie_in_tready,
    output logic                            pcie_out_tvalid,
    output logic                            pcie_out_tlast,
    output logic [C_DATA_WIDTH-1:0]         pcie_out_tdata,
    output logic [KEEP_WIDTH-1:0]           pcie_out_tkeep,
    output logic [TUSER_WIDTH-1:0]          pcie_out_tuser,
    input  logic                            pcie_out_tready,
    output logic                            arb_busy,
    output logic [1:0]                      arb_grant_idx,
    output logic [15:0]                     wdt_timeout_cnt
);
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || WDT_CYCLES < 1) begin : g_bad_cfg
        $error("pcie_tx_arbiter: unsupported NUM_REQ or WDT_CYCLES");
    end

    state_t                          state_q, state_d;
    logic [1:0]                      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]              ack_q, ack_d;
    logic                            started_q, started_d;
    logic                            pick_valid, busy, fire, wdt_expire;
    logic [1:0]                      pick_idx;
    logic [MAX_REQ-1:0]              req_x, valid_x, last_x;
    logic [MAX_REQ*C_DATA_WIDTH-1:0] data_x;
    logic [MAX_REQ*KEEP_WIDTH-1:0]   keep_x;
    logic [MAX_REQ*TUSER_WIDTH-1:0]  user_x;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i  (pcie_in_req),
        .ptr_i  (ptr_q),
        .valid_o(pick_valid),
        .idx_o  (pick_idx)
    );

    // Widen to MAX_REQ so the 2-bit grant index can address any build.
    assign req_x   = MAX_REQ'(pcie_in_req);
    assign valid_x = MAX_REQ'(pcie_in_tvalid);
    assign last_x  = MAX_REQ'(pcie_in_tlast);
    assign data_x  = (MAX_REQ*C_DATA_WIDTH)'(pcie_in_tdata);
    assign keep_x  = (MAX_REQ*KEEP_WIDTH)'(pcie_in_tkeep);
    assign user_x  = (MAX_REQ*TUSER_WIDTH)'(pcie_in_tuser);

    assign busy            = state_q == XFER;
    assign pcie_out_tvalid = busy & valid_x[ptr_q];
    assign pcie_out_tlast  = busy & last_x[ptr_q];
    assign pcie_out_tdata  = busy ? data_x[int'(ptr_q)*C_DATA_WIDTH +: C_DATA_WIDTH] : '0;
    assign pcie_out_tkeep  = busy ? keep_x[int'(ptr_q)*KEEP_WIDTH +: KEEP_WIDTH] : '0;
    assign pcie_out_tuser  = busy ? user_x[int'(ptr_q)*TUSER_WIDTH +: TUSER_WIDTH] : '0;
    assign fire            = pcie_out_tvalid & pcie_out_tready;
    assign pcie_in_tready  = ack_q & {NUM_REQ{pcie_out_tready}};
    assign pcie_in_ack     = ack_q;
    assign arb_busy        = busy;
    assign arb_grant_idx   = ptr_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ack_d     = ack_q;
        started_d = started_q;
        if (!busy) begin
            if (pick_valid) begin
                state_d   = XFER;
                ptr_d     = pick_idx;
                ack_d     = NUM_REQ'(1) << pick_idx;
                started_d = 1'b0;
            end
        end else if ((fire && last_x[ptr_q]) || (!started_q && !fire && (!req_x[ptr_q] || wdt_expire))) begin
            state_d = IDLE;
            ack_d   = '0;
        end else begin
            started_d = started_q | fire;
        end
    end

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            ack_q     <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            started_q <= started_d;
        end
    end

`ifdef PCIE_TX_ARB_WDT_EN
    logic        waiting;
    logic [31:0] wdt_q;
    logic [15:0] tmo_q;
    // Only the gap between ack and the first accepted beat is policed.
    assign waiting         = busy & !started_q & !fire;
    assign wdt_expire      = waiting && wdt_q == 32'(WDT_CYCLES - 1);
    assign wdt_timeout_cnt = tmo_q;

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            wdt_q <= '0;
            tmo_q <= '0;
        end else begin
            wdt_q <= waiting ? wdt_q + 32'd1 : '0;
            tmo_q <= tmo_q + 16'(wdt_expire && tmo_q != 16'hFFFF);
        end
    end
`else
    assign wdt_expire      = 1'b0;
    assign wdt_timeout_cnt = '0;
`endif
endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// tb_pcie_tx_arbiter: directed and randomized checks of pcie_tx_arbiter against a packet-level model.
// Honours PCIE_TX_ARB_WDT_EN to select the watchdog or the hold-forever expectation.
module tb_pcie_tx_arbiter;
    localparam int N   = 2;
    localparam int W   = 64;
    localparam int K   = 8;
    localparam int WDT = 16;
    localparam int OW  = 2*N + W + K + 25;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req, ack, tv, tl, trdy;
    logic [N*W-1:0] td;
    logic [N*K-1:0] tk;
    logic [N*4-1:0] tu;
    logic           otv, otl, ordy, busy;
    logic [W-1:0]   otd;
    logic [K-1:0]   otk;
    logic [3:0]     otu;
    logic [1:0]     gidx;
    logic [15:0]    wcnt;

    pcie_tx_arbiter #(.C_DATA_WIDTH(W), .NUM_REQ(N), .WDT_CYCLES(WDT)) dut (
        .pcie_clk(clk), .pcie_rst_n(rst_n),
        .pcie_in_req(req), .pcie_in_ack(ack),
        .pcie_in_tvalid(tv), .pcie_in_tlast(tl),
        .pcie_in_tdata(td), .pcie_in_tkeep(tk), .pcie_in_tuser(tu),
        .pcie_in_tready(trdy),
        .pcie_out_tvalid(otv), .pcie_out_tlast(otl),
        .pcie_out_tdata(otd), .pcie_out_tkeep(otk), .pcie_out_tuser(otu),
        .pcie_out_tready(ordy),
        .arb_busy(busy), .arb_grant_idx(gidx), .wdt_timeout_cnt(wcnt)
    );

    int checks = 0;
    int errors = 0;

    int          len[N], bi[N], gap[N];
    bit          want[N], en[N], vfix[N], vcur[N];
    logic [31:0] salt[N];
    int          plen = 0, gmax = 0, rmode = 0;
    bit          vrand = 0;

    // Packet-level reference: who owns the port, who was granted last, watchdog age.
    int owner = -1, last = 0, wd = 0, tmo = 0;
    bit started = 0;

    int         cyc = 0;
    logic [N-1:0] prev_ack = '0;
    int         rise_c[$], rise_i[$], fall_c[$], tl_c[$];
    logic [W-1:0] cap[$];

    function automatic logic [W-1:0] bdat(int i, int b);
        return {salt[i], 16'(i), 16'(b)};
    endfunction

    function automatic int qget(int q[$], int k);
        return (q.size() > k) ? q[k] : -1;
    endfunction

    task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic new_pkt(int i, int l);
        want[i] = 1; len[i] = l; bi[i] = 0; salt[i] = $urandom;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            vcur[i] = vrand ? ($urandom_range(3) != 0) : vfix[i];
            req[i]  = want[i];
            tv[i]   = want[i] && vcur[i];
            tl[i]   = want[i] && (bi[i] == len[i] - 1);
            td[i*W +: W] = bdat(i, bi[i]);
            tk[i*K +: K] = tl[i] ? 8'h0F : 8'hFF;
            tu[i*4 +: 4] = 4'(bi[i]*2 + i + 1);
        end
        ordy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(1));
    endtask

    task automatic clear();
        rise_c.delete(); rise_i.delete(); fall_c.delete(); tl_c.delete(); cap.delete();
    endtask

    task automatic model_reset();
        owner = -1; last = 0; started = 0; wd = 0; tmo = 0; prev_ack = '0;
    endtask

    task automatic check_zero(string tag);
        chk(tag, 64'({ack, trdy, otv, otl, busy, gidx, wcnt}), 64'd0);
        chk({tag, "_data"}, {otd ^ 64'(otk), 4'd0, otu} == '0 ? 64'd0 : 64'd1, 64'd0);
    endtask

    task automatic check_cycle();
        logic [N-1:0] e_ack, e_rdy;
        logic         e_tv, e_tl;
        logic [W-1:0] e_td;
        logic [K-1:0] e_tk;
        logic [3:0]   e_tu;
        logic [OW-1:0] obs, exp_v;
        e_ack = '0; e_rdy = '0; e_tv = 0; e_tl = 0; e_td = '0; e_tk = '0; e_tu = '0;
        if (owner >= 0) begin
            e_ack[owner] = 1'b1;
            e_rdy[owner] = ordy;
            e_tv = want[owner] && vcur[owner];
            e_tl = want[owner] && (bi[owner] == len[owner] - 1);
            e_td = bdat(owner, bi[owner]);
            e_tk = e_tl ? 8'h0F : 8'hFF;
            e_tu = 4'(bi[owner]*2 + owner + 1);
        end
        obs   = {ack, trdy, otv, otl, otd, otk, otu, busy, gidx, wcnt};
        exp_v = {e_ack, e_rdy, e_tv, e_tl, e_td, e_tk, e_tu, owner >= 0, 2'(last), 16'(tmo)};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL cycle %0d: observed %h expected %h", cyc, obs, exp_v);
        end
        if (otv && ordy) begin
            cap.push_back(otd);
            if (otl) tl_c.push_back(cyc);
        end
        if (ack != 0 && prev_ack == 0) begin
            rise_c.push_back(cyc);
            rise_i.push_back(ack[1] ? 1 : 0);
        end
        if (ack == 0 && prev_ack != 0) fall_c.push_back(cyc);
        prev_ack = ack;
    endtask

    task automatic model_next(output int fi, output bit fl);
        fi = -1; fl = 0;
        if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (last + k) % N;
                if (owner < 0 && want[j]) begin
                    owner = j; last = j; started = 0; wd = 0;
                end
            end
        end else begin
            bit f;
            f = want[owner] && vcur[owner] && ordy;
            if (f) begin
                fi = owner;
                fl = (bi[owner] == len[owner] - 1);
            end
            if (f && fl) owner = -1;
            else if (!f && !started && !want[owner]) owner = -1;
            else if (f) started = 1;
`ifdef PCIE_TX_ARB_WDT_EN
            else if (!started) begin
                wd++;
                if (wd == WDT) begin
                    owner = -1;
                    if (tmo < 65535) tmo++;
                end
            end
`endif
        end
    endtask

    task automatic src_update(int fi, bit fl);
        for (int i = 0; i < N; i++) begin
            if (i == fi) begin
                if (fl) begin
                    want[i] = 0;
                    gap[i] = (gmax > 0) ? int'($urandom_range(gmax)) : 0;
                end else bi[i]++;
            end else if (!want[i] && en[i]) begin
                if (gap[i] == 0) new_pkt(i, (plen > 0) ? plen : int'($urandom_range(4, 1)));
                else gap[i]--;
            end
        end
    endtask

    task automatic step();
        int fi;
        bit fl;
        @(negedge clk);
        check_cycle();
        model_next(fi, fl);
        @(posedge clk);
        #1;
        src_update(fi, fl);
        cyc++;
        drive();
    endtask

    initial begin
        int r, t;
        for (int i = 0; i < N; i++) begin
            want[i] = 0; en[i] = 0; vfix[i] = 1; gap[i] = 0; len[i] = 1; bi[i] = 0; salt[i] = '0;
        end
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        drive();

        // Single source, 3-beat packet
        clear();
        r = cyc;
        new_pkt(0, 3);
        drive();
        repeat (8) step();
        chk("a_ack_lat", 64'(qget(rise_c, 0)), 64'(r + 1));
        chk("a_beats", 64'(cap.size()), 64'd3);
        for (int b = 0; b < 3; b++) chk("a_data", cap.size() > b ? cap[b] : 'x, bdat(0, b));
        chk("a_fall", 64'(qget(fall_c, 0)), 64'(qget(tl_c, 0) + 1));

        // Two continuous requesters, 2-beat packets
        clear();
        plen = 2; gmax = 0; en[0] = 1; en[1] = 1;
        repeat (24) step();
        en[0] = 0; en[1] = 0;
        repeat (12) step();
        for (int k = 0; k < 4; k++) chk("b_grant", 64'(qget(rise_i, k)), (k % 2 == 0) ? 64'd1 : 64'd0);
        for (int k = 0; k < 3; k++) chk("b_gap", 64'(qget(rise_c, k + 1) - qget(fall_c, k)), 64'd1);

        // Toggling downstream ready during a 4-beat packet
        clear();
        rmode = 1;
        new_pkt(0, 4);
        drive();
        repeat (14) step();
        rmode = 0;
        chk("c_beats", 64'(cap.size()), 64'd4);
        for (int b = 0; b < 4; b++) chk("c_data", cap.size() > b ? cap[b] : 'x, bdat(0, b));

        // Grant withdrawn when req drops before the first beat
        clear();
        vfix[1] = 0;
        new_pkt(1, 2);
        drive();
        repeat (2) step();
        want[1] = 0;
        drive();
        repeat (2) step();
        chk("wd_ack", 64'(ack), 64'd0);
        chk("wd_idx", 64'(gidx), 64'd1);
        chk("wd_rise", 64'(rise_c.size()), 64'd1);
        vfix[1] = 1;

        // Randomized traffic, then asynchronous reset mid-packet
        plen = 0; gmax = 3; vrand = 1; rmode = 2; en[0] = 1; en[1] = 1;
        repeat (400) step();
        t = 0;
        while (!(owner >= 0 && started) && t < 50) begin
            step();
            t++;
        end
        chk("rst_wait", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        for (int i = 0; i < N; i++) if (want[i]) bi[i] = 0;
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear();
        repeat (6) step();
        chk("rst_regrant", 64'(rise_c.size() > 0), 64'd1);
        repeat (150) step();
        en[0] = 0; en[1] = 0; vrand = 0; rmode = 0;
        repeat (30) step();
        chk("drain", 64'(ack), 64'd0);

        // Granted source that never sends
        clear();
        vfix[1] = 0;
        new_pkt(1, 2);
        drive();
        step();
        new_pkt(0, 1);
        drive();
`ifdef PCIE_TX_ARB_WDT_EN
        repeat (24) step();
        chk("wdt_len", 64'(qget(fall_c, 0) - qget(rise_c, 0)), 64'(WDT));
        chk("wdt_cnt", 64'(wcnt), 64'd1);
        chk("wdt_next", 64'(qget(rise_i, 1)), 64'd0);
`else
        repeat (1000) step();
        chk("hold_ack", 64'(ack), 64'd2);
        chk("hold_wdt", 64'(wcnt), 64'd0);
        chk("hold_fall", 64'(fall_c.size()), 64'd0);
`endif
        vfix[1] = 1;
        repeat (12) step();
        chk("final_idle", 64'(ack), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Round-robin scheduler that shares the single PCIe core transmit AXI-Stream port between up to four TLP sources, such as the TX engine, the Ethernet-decapsulated TLP path and the configuration responder. Each source requests the port with a req/ack handshake and receives exclusive ownership for exactly one packet. The grant always moves on a TLP boundary. The block sits in the pcie_clk domain, between the TLP sources and the pcie_support transmit interface.

## Interface
- C_DATA_WIDTH, 64, TLP stream data width
- KEEP_WIDTH, C_DATA_WIDTH/8, tkeep width
- NUM_REQ, 2, number of requesters (2..4)
- WDT_CYCLES, 256, ack-to-first-beat timeout (watchdog build only)

Ports:
- pcie_clk  in  1  clock (only clock)
- pcie_rst_n  in  1  asynchronous, active-low reset
- pcie_in_req  in  NUM_REQ  per-source request, level
- pcie_in_ack  out  NUM_REQ  per-source grant, one-hot or zero
- pcie_in_tvalid / pcie_in_tlast  in  NUM_REQ  per-source stream control
- pcie_in_tdata  in  NUM_REQ*C_DATA_WIDTH  packed data, source i at slice i
- pcie_in_tkeep  in  NUM_REQ*KEEP_WIDTH  packed keep
- pcie_in_tuser  in  NUM_REQ*4  packed tuser
- pcie_in_tready  out  NUM_REQ  per-source ready
- pcie_out_tvalid / pcie_out_tlast  out  1  to PCIe core
- pcie_out_tdata / pcie_out_tkeep / pcie_out_tuser  out  C_DATA_WIDTH / KEEP_WIDTH / 4  to PCIe core
- pcie_out_tready  in  1  from PCIe core
- arb_busy  out  1  a grant is active
- arb_grant_idx  out  2  index of the current or last granted source
- wdt_timeout_cnt  out  16  count of revoked grants (tied to 0 without watchdog)

## Operation
- The FSM has two states, IDLE and XFER. Reset places the FSM in IDLE.
- Reset values: every output 0, round-robin pointer 0.
- In IDLE, if any req is high, the arbiter picks the first requesting source starting at pointer+1 (mod NUM_REQ).
  - It registers ack for that source and enters XFER.
  - The pointer is set to the picked index.
- In XFER:
  - pcie_out_* is a combinational mux of the granted source.
  - The granted tready equals pcie_out_tready.
  - All other tready and ack outputs are 0.
- On a beat with tvalid, tready and tlast all high:
  - ack drops on the next edge and the FSM returns to IDLE.
  - A requester must drop req on that same edge. It re-raises req to queue another packet.
- Outside XFER, pcie_out_tvalid is 0. Data, keep and user are forced to 0.
- A source that drops req while granted, before its first beat, has its grant withdrawn on the next edge. That source becomes the pointer.
- tvalid without ack is ignored. A source does not lose data because tready stays 0.
- If the arbiter is reset mid-packet, the packet is truncated at the output. Downstream recovery is the PCIe core's responsibility.

## Timing
- Request-to-ack latency is 1 cycle from IDLE.
- ack-to-data latency is 0 cycles: the first beat may pass in the first ack cycle.
- Datapath is combinational with no added latency. pcie_out_tready reaches tready through one AND gate.
- Back-to-back packets: the tlast beat is at cycle T, IDLE is at T+1, the next ack is at T+2. Minimum inter-packet gap is 1 cycle.
- With all sources requesting continuously, grants rotate 0,1,…,NUM_REQ-1. No source waits more than NUM_REQ-1 packets.

## Configuration
- PCIE_TX_ARB_WDT_EN defined:
  - A counter runs while ack is high and no beat has been accepted yet.
  - When the counter reaches WDT_CYCLES, the grant is revoked and the FSM goes to IDLE.
  - wdt_timeout_cnt increments and saturates at 0xFFFF.
  - A grant is never revoked after the first beat has been accepted.
- PCIE_TX_ARB_WDT_EN undefined:
  - No counter logic is built and wdt_timeout_cnt is tied to 0.
  - A granted source may hold the port indefinitely.

## Structure
- Package pcie_tx_arb_pkg holds the state enum (IDLE, XFER), the TUSER_WIDTH=4 constant and the MAX_REQ=4 constant.
- Sub-module rr_pick: combinational round-robin next-index selection from the req vector and the pointer. It outputs valid and idx.

## Test plan
- Source 0 alone sends a 3-beat TLP with pcie_out_tready=1 -> ack[0] rises 1 cycle after req; 3 output beats match the input; ack falls the cycle after tlast.
- Sources 0 and 1 request continuously with 2-beat packets -> grants alternate 1,0,1,0 starting after reset; exactly 1 idle cycle between packets.
- pcie_out_tready toggles 1,0,1,0 during a 4-beat packet -> no beat is duplicated or lost; tready to the source mirrors pcie_out_tready.
- pcie_rst_n asserted mid-packet, asynchronously -> all outputs reach 0 immediately; the next req is granted normally after release.
- Watchdog build, WDT_CYCLES=16, source 1 is granted but sends no tvalid -> ack[1] drops after 16 cycles; wdt_timeout_cnt=1; pending source 0 is granted next.
- Non-watchdog build, same stimulus -> ack[1] holds for 1000 cycles; wdt_timeout_cnt stays 0.
